// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback command encodings, FSM state type and r15 address default
package wb_pkg;

    typedef enum logic [1:0] {
        WB_NONE    = 2'b00,
        WB_OP1     = 2'b01,
        WB_OP1_OP2 = 2'b10,
        WB_OP1_R15 = 2'b11
    } wb_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        TWO_A = 2'd2,
        TWO_B = 2'd3
    } wb_state_t;

    localparam logic [3:0] R15_ADDR_DEFAULT = 4'd15;

endpackage

// File: rtl/wb_stall_counter.sv
// rtl/wb_stall_counter.sv - 16-bit saturating stall-cycle counter, cleared only by reset
module wb_stall_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/wb_write_sequencer.sv
// rtl/wb_write_sequencer.sv - serialises MEM/WB writeback bundles onto one register-file write port; WB_STATS_EN adds stall_count
module wb_write_sequencer
    import wb_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] R15_ADDR = R15_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        rwrite,
    input  logic [ADDR_W-1:0] op1,
    input  logic [ADDR_W-1:0] op2,
    input  logic [DATA_W-1:0] op1data,
    input  logic [DATA_W-1:0] op2data,
    input  logic [DATA_W-1:0] r15data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef WB_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    wb_state_t         state;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    // TWO_A is the only state that cannot also retire the current bundle
    assign in_ready = (state != TWO_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pend_addr <= '0;
            pend_data <= '0;
        end else if (state == TWO_A) begin
            state    <= TWO_B;
            rf_we    <= 1'b1;
            rf_waddr <= pend_addr;
            rf_wdata <= pend_data;
        end else if (in_valid) begin
            case (wb_cmd_t'(rwrite))
                WB_NONE: begin
                    state <= IDLE;
                    rf_we <= 1'b0;
                end
                WB_OP1: begin
                    state    <= ONE;
                    rf_we    <= 1'b1;
                    rf_waddr <= op1;
                    rf_wdata <= op1data;
                end
                WB_OP1_OP2: begin
                    state     <= TWO_A;
                    rf_we     <= 1'b1;
                    rf_waddr  <= op1;
                    rf_wdata  <= op1data;
                    pend_addr <= op2;
                    pend_data <= op2data;
                end
                default: begin
                    state     <= TWO_A;
                    rf_we     <= 1'b1;
                    rf_waddr  <= op1;
                    rf_wdata  <= op1data;
                    pend_addr <= R15_ADDR;
                    pend_data <= r15data;
                end
            endcase
        end else begin
            state <= IDLE;
            rf_we <= 1'b0;
        end
    end

`ifdef WB_STATS_EN
    wb_stall_counter u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_valid & ~in_ready),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// tb/tb_wb_write_sequencer.sv - directed self-checking bench for wb_write_sequencer
module tb_wb_write_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  rwrite;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [15:0] op1data;
    logic [15:0] op2data;
    logic [15:0] r15data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
`ifdef WB_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wb_write_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rwrite      (rwrite),
        .op1         (op1),
        .op2         (op2),
        .op1data     (op1data),
        .op2data     (op2data),
        .r15data     (r15data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
`ifdef WB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [1:0] cmd, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] d15);
        in_valid = v;
        rwrite   = cmd;
        op1      = a1;
        op2      = a2;
        op1data  = d1;
        op2data  = d2;
        r15data  = d15;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string tag, input logic we, input logic [3:0] a,
                             input logic [15:0] d, input logic rdy);
        check({tag, "_we"}, 32'(rf_we), 32'(we));
        check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
        check({tag, "_data"}, 32'(rf_wdata), 32'(d));
        check({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    endtask

    initial begin
        rst_n = 1'b0;
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        #12;
        expect_wr("reset", 1'b0, 4'd0, 16'h0000, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_reset_ready", 32'(in_ready), 32'd1);

        // single write
        offer(1'b1, 2'b01, 4'd3, 4'd0, 16'h1234, 16'h0, 16'h0);
        step();
        expect_wr("single", 1'b1, 4'd3, 16'h1234, 1'b1);

        // dual write op1 then op2
        offer(1'b1, 2'b10, 4'd2, 4'd5, 16'hAAAA, 16'h5555, 16'h0);
        step();
        expect_wr("dual_a", 1'b1, 4'd2, 16'hAAAA, 1'b0);
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        expect_wr("dual_b", 1'b1, 4'd5, 16'h5555, 1'b1);
        step();
        expect_wr("dual_idle", 1'b0, 4'd5, 16'h5555, 1'b1);

        // back-to-back stream 11, 01, 00, 11
        offer(1'b1, 2'b11, 4'd1, 4'd9, 16'h1111, 16'h9999, 16'hF00F);
        step();
        expect_wr("s0_op1", 1'b1, 4'd1, 16'h1111, 1'b0);
        step();
        expect_wr("s0_r15", 1'b1, 4'd15, 16'hF00F, 1'b1);
        offer(1'b1, 2'b01, 4'd4, 4'd9, 16'h4444, 16'h9999, 16'h9999);
        step();
        expect_wr("s1_op1", 1'b1, 4'd4, 16'h4444, 1'b1);
        offer(1'b1, 2'b00, 4'd8, 4'd9, 16'h8888, 16'h9999, 16'h9999);
        step();
        expect_wr("s2_null", 1'b0, 4'd4, 16'h4444, 1'b1);
        offer(1'b1, 2'b11, 4'd6, 4'd9, 16'h6666, 16'h9999, 16'h0F0F);
        step();
        expect_wr("s3_op1", 1'b1, 4'd6, 16'h6666, 1'b0);
        step();
        expect_wr("s3_r15", 1'b1, 4'd15, 16'h0F0F, 1'b1);
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        expect_wr("s_idle", 1'b0, 4'd15, 16'h0F0F, 1'b1);

        // collision: op1 == r15, second write wins
        offer(1'b1, 2'b11, 4'd15, 4'd0, 16'h0001, 16'h0, 16'h0002);
        step();
        expect_wr("coll_a", 1'b1, 4'd15, 16'h0001, 1'b0);
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        expect_wr("coll_b", 1'b1, 4'd15, 16'h0002, 1'b1);
        step();
        expect_wr("coll_idle", 1'b0, 4'd15, 16'h0002, 1'b1);

        // reset during TWO_A discards the pending op2 write
        offer(1'b1, 2'b10, 4'd7, 4'd8, 16'h7777, 16'h8888, 16'h0);
        step();
        expect_wr("rst_two_a", 1'b1, 4'd7, 16'h7777, 1'b0);
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        expect_wr("rst_async", 1'b0, 4'd0, 16'h0000, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        expect_wr("rst_after", 1'b0, 4'd0, 16'h0000, 1'b1);
        step();
        expect_wr("rst_after2", 1'b0, 4'd0, 16'h0000, 1'b1);

`ifdef WB_STATS_EN
        check("stall_reset", 32'(stall_count), 32'd0);
        offer(1'b1, 2'b10, 4'd2, 4'd3, 16'h0202, 16'h0303, 16'h0);
        repeat (6) step();
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        check("stall_three", 32'(stall_count), 32'd3);
        force dut.u_stall_counter.count = 16'hFFFE;
        #1 release dut.u_stall_counter.count;
        offer(1'b1, 2'b10, 4'd2, 4'd3, 16'h0202, 16'h0303, 16'h0);
        repeat (6) step();
        offer(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        check("stall_sat", 32'(stall_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
